// File: rtl/core_axi_bridge_pkg.sv
// Shared constants and encodings for the core-to-AXI4 bridge.
package core_axi_bridge_pkg;

    // AXI burst size encodings (bytes per beat = 2**size)
    localparam logic [2:0] AXI_SIZE_4B   = 3'd2;
    localparam logic [2:0] AXI_SIZE_8B   = 3'd3;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Byte strobe width of the 64-bit memory bus
    localparam int unsigned BUS_AXI_STRB = 8;

    // Bridge FSM states
    typedef enum logic [2:0] {
        BRG_IDLE = 3'd0,
        BRG_AR   = 3'd1,
        BRG_R    = 3'd2,
        BRG_AW_W = 3'd3,
        BRG_B    = 3'd4
    } brg_state_e;

    // Source of the transaction currently owning the bus
    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_STORE = 2'd1;
    localparam logic [1:0] SRC_LOAD  = 2'd2;
    localparam logic [1:0] SRC_FETCH = 2'd3;

endpackage

// File: rtl/core_axi_bridge_arbiter.sv
// Fixed-priority request arbiter: store > load > fetch, among unserved requests.
module brg_arbiter
    import core_axi_bridge_pkg::*;
(
    input  logic       instr_rd_en_i,
    input  logic       mem_rd_en_i,
    input  logic       mem_wr_en_i,
    input  logic       instr_rdy_i,
    input  logic       mem_rdy_i,
    input  logic       store_done_i,  // store half of a store+load pair already finished
    output logic       grant_o,
    output logic [1:0] src_o
);

    logic store_req;
    logic load_req;
    logic fetch_req;

    // A load paired with a store waits until the store has completed.
    assign store_req = mem_wr_en_i & ~mem_rdy_i & ~store_done_i;
    assign load_req  = mem_rd_en_i & ~mem_rdy_i & (~mem_wr_en_i | store_done_i);
    assign fetch_req = instr_rd_en_i & ~instr_rdy_i;

    // Priority select of the winning requester
    always_comb begin
        grant_o = 1'b1;
        src_o   = SRC_NONE;
        if (store_req) begin
            src_o = SRC_STORE;
        end else if (load_req) begin
            src_o = SRC_LOAD;
        end else if (fetch_req) begin
            src_o = SRC_FETCH;
        end else begin
            grant_o = 1'b0;
        end
    end

endmodule

// File: rtl/core_axi_bridge.sv
// Bridge from the core's fetch and load/store requests to one single-beat AXI4 master.
module core_axi_bridge
    import core_axi_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned INSTR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    // core side
    input  logic                instr_rd_en_i,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                mem_rd_en_i,
    input  logic [ADDR_W-1:0]   addr_mem_rd_i,
    input  logic                mem_wr_en_i,
    input  logic [ADDR_W-1:0]   addr_mem_wr_i,
    input  logic [DATA_W-1:0]   data_mem_wr_i,
    input  logic [DATA_W/8-1:0] strb_mem_wr_i,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [ADDR_W-1:0]   addr_instr_o,
    output logic [DATA_W-1:0]   data_mem_o,
    output logic                stall_if_o,
    output logic                stall_mem_o,
    output logic                bus_err_o,
    // AXI write address
    output logic                axi_aw_valid_o,
    input  logic                axi_aw_ready_i,
    output logic [ADDR_W-1:0]   axi_aw_addr_o,
    output logic [2:0]          axi_aw_size_o,
    // AXI write data
    output logic                axi_w_valid_o,
    input  logic                axi_w_ready_i,
    output logic [DATA_W-1:0]   axi_w_data_o,
    output logic [DATA_W/8-1:0] axi_w_strb_o,
    output logic                axi_w_last_o,
    // AXI write response
    input  logic                axi_b_valid_i,
    output logic                axi_b_ready_o,
    input  logic [1:0]          axi_b_resp_i,
    // AXI read address
    output logic                axi_ar_valid_o,
    input  logic                axi_ar_ready_i,
    output logic [ADDR_W-1:0]   axi_ar_addr_o,
    output logic [2:0]          axi_ar_size_o,
    // AXI read data
    input  logic                axi_r_valid_i,
    output logic                axi_r_ready_o,
    input  logic [DATA_W-1:0]   axi_r_data_i,
    input  logic [1:0]          axi_r_resp_i,
    input  logic                axi_r_last_i
);

    brg_state_e state_q, state_d;

    logic [1:0]          src_q, src_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W/8-1:0] strb_q, strb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    logic                instr_rdy_q, instr_rdy_d;
    logic                mem_rdy_q, mem_rdy_d;
    logic                store_done_q, store_done_d;

    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_instr_q, addr_instr_d;
    logic [DATA_W-1:0]   data_mem_q, data_mem_d;
    logic                bus_err_q, bus_err_d;

    logic                grant;
    logic [1:0]          grant_src;
    logic                r_hs;
    logic                b_hs;
    logic                advance;
    logic                unused_r_last;

    // Single-beat reads never need RLAST.
    assign unused_r_last = axi_r_last_i;

    brg_arbiter u_arbiter (
        .instr_rd_en_i (instr_rd_en_i),
        .mem_rd_en_i   (mem_rd_en_i),
        .mem_wr_en_i   (mem_wr_en_i),
        .instr_rdy_i   (instr_rdy_q),
        .mem_rdy_i     (mem_rdy_q),
        .store_done_i  (store_done_q),
        .grant_o       (grant),
        .src_o         (grant_src)
    );

    assign r_hs    = (state_q == BRG_R) & axi_r_valid_i;
    assign b_hs    = (state_q == BRG_B) & axi_b_valid_i;

    assign stall_if_o  = instr_rd_en_i & ~instr_rdy_q;
    assign stall_mem_o = (mem_rd_en_i | mem_wr_en_i) & ~mem_rdy_q;
    assign advance     = ~stall_if_o & ~stall_mem_o;

    assign instr_o      = instr_q;
    assign addr_instr_o = addr_instr_q;
    assign data_mem_o   = data_mem_q;
    assign bus_err_o    = bus_err_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BRG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BRG_IDLE: begin
                if (grant) begin
                    state_d = (grant_src == SRC_STORE) ? BRG_AW_W : BRG_AR;
                end
            end
            BRG_AR:   if (axi_ar_ready_i) state_d = BRG_R;
            BRG_R:    if (axi_r_valid_i)  state_d = BRG_IDLE;
            BRG_AW_W: begin
                if ((aw_done_q | axi_aw_ready_i) & (w_done_q | axi_w_ready_i)) begin
                    state_d = BRG_B;
                end
            end
            BRG_B:    if (axi_b_valid_i)  state_d = BRG_IDLE;
            default:  state_d = BRG_IDLE;
        endcase
    end

    // FSM outputs: AXI handshake signals and fixed attributes
    always_comb begin
        axi_ar_valid_o = (state_q == BRG_AR);
        axi_r_ready_o  = (state_q == BRG_R);
        axi_aw_valid_o = (state_q == BRG_AW_W) & ~aw_done_q;
        axi_w_valid_o  = (state_q == BRG_AW_W) & ~w_done_q;
        axi_b_ready_o  = (state_q == BRG_B);
        axi_ar_addr_o  = addr_q;
        axi_ar_size_o  = (src_q == SRC_FETCH) ? AXI_SIZE_4B : AXI_SIZE_8B;
        axi_aw_addr_o  = addr_q;
        axi_aw_size_o  = AXI_SIZE_8B;
        axi_w_data_o   = data_q;
        axi_w_strb_o   = strb_q;
        axi_w_last_o   = 1'b1;
    end

    // Latch the winning request at IDLE exit; track AW/W completion independently
    always_comb begin
        src_d     = src_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        aw_done_d = (state_q == BRG_AW_W) & (aw_done_q | axi_aw_ready_i);
        w_done_d  = (state_q == BRG_AW_W) & (w_done_q | axi_w_ready_i);
        if ((state_q == BRG_IDLE) && grant) begin
            src_d  = grant_src;
            data_d = data_mem_wr_i;
            strb_d = strb_mem_wr_i;
            unique case (grant_src)
                SRC_STORE: addr_d = addr_mem_wr_i;
                SRC_LOAD:  addr_d = addr_mem_rd_i;
                default:   addr_d = pc_i;
            endcase
        end
    end

    // Served flags; a result for a request the core has since dropped sets nothing
    always_comb begin
        instr_rdy_d  = instr_rdy_q;
        mem_rdy_d    = mem_rdy_q;
        store_done_d = store_done_q;
        if (advance) begin
            instr_rdy_d  = 1'b0;
            mem_rdy_d    = 1'b0;
            store_done_d = 1'b0;
        end
        if (r_hs && (src_q == SRC_FETCH) && instr_rd_en_i) begin
            instr_rdy_d = 1'b1;
        end
        if (r_hs && (src_q == SRC_LOAD) && mem_rd_en_i) begin
            mem_rdy_d    = 1'b1;
            store_done_d = 1'b0;
        end
        if (b_hs && mem_wr_en_i) begin
            if (mem_rd_en_i) begin
                store_done_d = 1'b1;
            end else begin
                mem_rdy_d = 1'b1;
            end
        end
        // Load half of a pair withdrawn after its store finished: the store alone is served.
        if ((state_q == BRG_IDLE) && store_done_q && mem_wr_en_i && !mem_rd_en_i) begin
            mem_rdy_d    = 1'b1;
            store_done_d = 1'b0;
        end
    end

    // Result capture and error pulse
    always_comb begin
        instr_d      = instr_q;
        addr_instr_d = addr_instr_q;
        data_mem_d   = data_mem_q;
        bus_err_d    = (r_hs && (axi_r_resp_i != AXI_RESP_OKAY)) ||
                       (b_hs && (axi_b_resp_i != AXI_RESP_OKAY));
        if (r_hs && (src_q == SRC_FETCH) && instr_rd_en_i) begin
            instr_d      = addr_q[2] ? axi_r_data_i[INSTR_W +: INSTR_W]
                                     : axi_r_data_i[0 +: INSTR_W];
            addr_instr_d = addr_q;
        end
        if (r_hs && (src_q == SRC_LOAD) && mem_rd_en_i) begin
            data_mem_d = axi_r_data_i;
        end
    end

    // Datapath and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q        <= SRC_NONE;
            addr_q       <= '0;
            data_q       <= '0;
            strb_q       <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            instr_rdy_q  <= 1'b0;
            mem_rdy_q    <= 1'b0;
            store_done_q <= 1'b0;
            instr_q      <= '0;
            addr_instr_q <= '0;
            data_mem_q   <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            src_q        <= src_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            instr_rdy_q  <= instr_rdy_d;
            mem_rdy_q    <= mem_rdy_d;
            store_done_q <= store_done_d;
            instr_q      <= instr_d;
            addr_instr_q <= addr_instr_d;
            data_mem_q   <= data_mem_d;
            bus_err_q    <= bus_err_d;
        end
    end

endmodule

// File: doc/core_axi_bridge.md
Name: core_axi_bridge

Overview:
- Sits directly downstream of the pipeline core and is the core's only path to memory.
- Turns the core's instruction-fetch request and its data load/store request into single-beat AXI4 transactions on one shared master port.
- Returns fetched instructions and load data to the core, and drives the core's stall_if / stall_mem inputs.
- Allows one outstanding transaction at a time.

Parameters:
ADDR_W, 64, address width (matches BUS_ADDR_MEM)
DATA_W, 64, data bus width (matches BUS_DATA_MEM)
INSTR_W, 32, instruction width (matches BUS_DATA_INSTR)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
instr_rd_en_i  in  1  fetch request from core
pc_i  in  ADDR_W  fetch address; 4-byte aligned
mem_rd_en_i  in  1  load request
addr_mem_rd_i  in  ADDR_W  load address
mem_wr_en_i  in  1  store request
addr_mem_wr_i  in  ADDR_W  store address
data_mem_wr_i  in  DATA_W  store data
strb_mem_wr_i  in  DATA_W/8  store byte strobes
instr_o  out  INSTR_W  fetched instruction
addr_instr_o  out  ADDR_W  address of instr_o
data_mem_o  out  DATA_W  raw 64-bit load data; lane extraction is done in EX
stall_if_o  out  1  fetch not yet served
stall_mem_o  out  1  load/store not yet served
bus_err_o  out  1  one-cycle pulse on non-OKAY RRESP/BRESP
axi_aw_valid_o/axi_aw_ready_i/axi_aw_addr_o[ADDR_W]/axi_aw_size_o[3]  write address channel
axi_w_valid_o/axi_w_ready_i/axi_w_data_o[DATA_W]/axi_w_strb_o[DATA_W/8]/axi_w_last_o  write data channel
axi_b_valid_i/axi_b_ready_o/axi_b_resp_i[2]  write response channel
axi_ar_valid_o/axi_ar_ready_i/axi_ar_addr_o[ADDR_W]/axi_ar_size_o[3]  read address channel
axi_r_valid_i/axi_r_ready_o/axi_r_data_i[DATA_W]/axi_r_resp_i[2]/axi_r_last_i  read data channel

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; all valid/ready outputs are 0.
  - instr_o=0 (NOP not inserted; IF masks), addr_instr_o=0, data_mem_o=0, bus_err_o=0.
  - Served flags are cleared; stall outputs then follow the combinational rule below.
- Reset mid-transaction: the transaction is abandoned. The interconnect is reset by the same rst_n.
- Stall rule (combinational):
  - stall_mem_o = (mem_rd_en_i|mem_wr_en_i) & ~mem_rdy.
  - stall_if_o = instr_rd_en_i & ~instr_rdy.
- Served flags:
  - mem_rdy and instr_rdy are each set in the cycle after that requester's response handshake.
  - Both are cleared on any clock edge where stall_if_o=0 and stall_mem_o=0, i.e. the pipeline advanced.
  - A request is never reissued while its rdy flag is set.
- Arbitration, evaluated in IDLE among unserved requests: store > load > fetch.
  - If mem_wr_en_i and mem_rd_en_i are both high, the store is done first, then the load. mem_rdy sets only after the second completes.
  - The winning request's address, data and strobes are latched at IDLE exit.
- FSM states and transitions:
  - IDLE -> AR (load/fetch) or AW_W (store).
  - AR: ar_valid=1 until ar_ready -> R.
  - R: r_ready=1; on r_valid -> IDLE.
    - Capture for fetch: instr_o = latched addr[2] ? r_data[63:32] : r_data[31:0]; addr_instr_o = latched pc.
    - Capture for load: data_mem_o = r_data.
  - AW_W: aw_valid and w_valid both assert together; each drops independently on its ready. When both are done -> B.
  - B: b_ready=1; on b_valid -> IDLE.
- Fixed transaction attributes:
  - ar_size = 2 for fetch, 3 for load; aw_size = 3.
  - w_last = 1; single beat only. r_last is ignored.
- Minimum latency for a fetch:
  - Request high at cycle N, ar_valid at N+1.
  - With ar_ready at N+1 and r_valid at N+2, instr_rdy=1 (stall_if_o low) at N+3.
  - Back-to-back requests incur one IDLE cycle.
- Output holding: instr_o, addr_instr_o and data_mem_o hold until the next capture.
- Errors: resp!=0 pulses bus_err_o for one cycle, coincident with the rdy set. Data is still captured and the flow proceeds normally.
- Request drop: if the core drops a request while its transaction is in flight, the transaction completes and the result is discarded. No rdy is set.

Decomposition:
- Shared define file gets:
  - AXI_SIZE_4B/AXI_SIZE_8B, AXI_RESP_OKAY.
  - State encodings BRG_IDLE/BRG_AR/BRG_R/BRG_AW_W/BRG_B.
  - BUS_AXI_STRB (already present).
- One natural sub-module: brg_arbiter. It is combinational, takes the request and rdy flags, and returns the grant and its source select.

Test Plan:
- Fetch pc=0x80000004, ar_ready immediate, r_data=0x11111111_22222222 next cycle -> instr_o=0x11111111, addr_instr_o=0x80000004, stall_if_o low 3 cycles after request.
- Store addr=0x80001000, data=0xDEADBEEF_CAFEF00D, strb=0x0F, w_ready 2 cycles after aw_ready -> single AW and single W seen, w_last=1, stall_mem_o drops after b_valid.
- Simultaneous fetch and load at 0x80002000 -> AR for load first (size 3), then fetch; stall_mem_o clears first.
- stall_if_o held while the load is served -> no second AR for the load; mem_rdy cleared only when both stalls are low.
- r_resp=2'b10 on a fetch -> bus_err_o one-cycle pulse, instr_o updated, FSM back in IDLE.
- rst_n pulled low during the R state -> all valids 0 immediately; after release, a new fetch is issued cleanly.
